// File: rtl/gpu_ram_arbiter_n_if.sv
// gpu_ram_arbiter_n_if: bundle of requester-side and GPU-RAM-side signals
// for the N-port GPU RAM arbiter. The slave modport is the arbiter itself.
// The master modport is the surrounding system: the requesters plus the RAM
// read-data return path.
interface gpu_ram_arbiter_n_if #(
   parameter int PORTS  = 4,
   parameter int ADDR_W = 20,
   parameter int DATA_W = 8
);
   logic [PORTS-1:0]        wr_ena;
   logic [PORTS-1:0]        rd_req;
   logic [PORTS*ADDR_W-1:0] address;
   logic [PORTS*DATA_W-1:0] data_in;
   logic [DATA_W-1:0]       gpu_data_in;
   logic                    gpu_wr_ena;
   logic [ADDR_W-1:0]       gpu_address;
   logic [DATA_W-1:0]       gpu_data_out;
   logic [PORTS-1:0]        gpu_rd_rdy;
   logic [PORTS*DATA_W-1:0] data_out;
   logic [PORTS-1:0]        busy;
   logic [PORTS-1:0]        overrun;

   modport slave (
      input  wr_ena, rd_req, address, data_in, gpu_data_in,
      output gpu_wr_ena, gpu_address, gpu_data_out, gpu_rd_rdy, data_out, busy, overrun
   );

   modport master (
      output wr_ena, rd_req, address, data_in, gpu_data_in,
      input  gpu_wr_ena, gpu_address, gpu_data_out, gpu_rd_rdy, data_out, busy, overrun
   );
endinterface

// File: rtl/gpu_ram_arbiter_n.sv
// gpu_ram_arbiter_n: round-robin arbiter from PORTS host requesters onto one
// GPU RAM port. Each request pulse lands in a per-port pending slot. At most
// one slot is granted per clock. Read results come back on data_out with a
// per-port gpu_rd_rdy pulse READ_CLOCK_CYCLES after the address is presented.
// Optional build macro GPU_RAM_ARB_RDLATCH_EN: data_out slices are registered
// per port and gpu_rd_rdy moves one clock later to line up with them.
module gpu_ram_arbiter_n #(
   parameter int PORTS             = 4,
   parameter int ADDR_W            = 20,
   parameter int DATA_W            = 8,
   parameter int READ_CLOCK_CYCLES = 2
) (
   input  logic               clk,
   input  logic               reset,
   gpu_ram_arbiter_n_if.slave bus
);
   localparam int IDX_W   = $clog2(PORTS);
   localparam int RD_LAST = READ_CLOCK_CYCLES - 1;

   // pending request slots
   logic [PORTS-1:0]  slot_vld;
   logic [PORTS-1:0]  slot_wr;
   logic [ADDR_W-1:0] slot_addr [PORTS];
   logic [DATA_W-1:0] slot_data [PORTS];
   logic [IDX_W-1:0]  rr_ptr;

   // arbitration and capture decisions for the coming edge
   logic              gnt_vld;
   logic [IDX_W-1:0]  gnt_idx;
   logic [PORTS-1:0]  req;
   logic [PORTS-1:0]  freeing;
   logic [PORTS-1:0]  take;
   logic [PORTS-1:0]  drop;

   // registered RAM-side outputs
   logic              gpu_wr_ena_r;
   logic [ADDR_W-1:0] gpu_addr_r;
   logic [DATA_W-1:0] gpu_dout_r;
   logic [PORTS-1:0]  overrun_r;

   // read-return pipeline: {valid, port} per stage
   logic              rd_vld_p  [READ_CLOCK_CYCLES];
   logic [IDX_W-1:0]  rd_port_p [READ_CLOCK_CYCLES];
   logic [PORTS-1:0]  rdy_ret;

   // First pending slot scanning upward from the pointer; the wrap is explicit so
   // non-power-of-two port counts scan correctly.
   always_comb begin
      int cand;
      cand    = 0;
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < PORTS; i++) begin
         cand = int'(rr_ptr) + i;
         if (cand >= PORTS) cand = cand - PORTS;
         if (!gnt_vld && slot_vld[cand[IDX_W-1:0]]) begin
            gnt_vld = 1'b1;
            gnt_idx = cand[IDX_W-1:0];
         end
      end
   end

   assign req = bus.wr_ena | bus.rd_req;

   // A slot being granted this edge can accept a new request on the same edge.
   always_comb begin
      freeing = '0;
      for (int p = 0; p < PORTS; p++) begin
         freeing[p] = gnt_vld && (gnt_idx == IDX_W'(p));
      end
   end

   assign take = req & (~slot_vld | freeing);
   assign drop = (bus.wr_ena & bus.rd_req) | (req & slot_vld & ~freeing);

   // Slot occupancy, round-robin pointer and the registered RAM-side outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot_vld     <= '0;
         rr_ptr       <= '0;
         gpu_wr_ena_r <= 1'b0;
         gpu_addr_r   <= '0;
         gpu_dout_r   <= '0;
         overrun_r    <= '0;
      end else begin
         slot_vld     <= (slot_vld & ~freeing) | take;
         overrun_r    <= drop;
         gpu_wr_ena_r <= gnt_vld & slot_wr[gnt_idx];
         if (gnt_vld) begin
            gpu_addr_r <= slot_addr[gnt_idx];
            gpu_dout_r <= slot_data[gnt_idx];
            rr_ptr     <= (gnt_idx == IDX_W'(PORTS - 1)) ? '0 : gnt_idx + 1'b1;
         end
      end
   end

   // Slot payload; only meaningful while slot_vld is set, so it carries no reset.
   // A write wins over a simultaneous read on the same port.
   always_ff @(posedge clk) begin
      for (int p = 0; p < PORTS; p++) begin
         if (take[p]) begin
            slot_wr[p]   <= bus.wr_ena[p];
            slot_addr[p] <= bus.address[p*ADDR_W +: ADDR_W];
            slot_data[p] <= bus.data_in[p*DATA_W +: DATA_W];
         end
      end
   end

   // Read-return valid bits shift with the RAM latency; reset discards in-flight reads.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < READ_CLOCK_CYCLES; i++) rd_vld_p[i] <= 1'b0;
         rdy_ret <= '0;
      end else begin
         rd_vld_p[0] <= gnt_vld & ~slot_wr[gnt_idx];
         for (int i = 1; i < READ_CLOCK_CYCLES; i++) rd_vld_p[i] <= rd_vld_p[i-1];
         for (int p = 0; p < PORTS; p++) begin
            rdy_ret[p] <= rd_vld_p[RD_LAST] && (rd_port_p[RD_LAST] == IDX_W'(p));
         end
      end
   end

   // Port index travelling alongside the read valid bits.
   always_ff @(posedge clk) begin
      rd_port_p[0] <= gnt_idx;
      for (int i = 1; i < READ_CLOCK_CYCLES; i++) rd_port_p[i] <= rd_port_p[i-1];
   end

`ifdef GPU_RAM_ARB_RDLATCH_EN
   logic [PORTS-1:0]        rdy_late;
   logic [PORTS*DATA_W-1:0] dout_lat;

   // Capture each port's read data on its return cycle and delay ready to match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdy_late <= '0;
         dout_lat <= '0;
      end else begin
         rdy_late <= rdy_ret;
         for (int p = 0; p < PORTS; p++) begin
            if (rdy_ret[p]) dout_lat[p*DATA_W +: DATA_W] <= bus.gpu_data_in;
         end
      end
   end

   assign bus.gpu_rd_rdy = rdy_late;
   assign bus.data_out   = dout_lat;
`else
   assign bus.gpu_rd_rdy = rdy_ret;
   // RAM data goes straight to every port; held at zero while reset is high.
   assign bus.data_out   = reset ? '0 : {PORTS{bus.gpu_data_in}};
`endif

   assign bus.gpu_wr_ena   = gpu_wr_ena_r;
   assign bus.gpu_address  = gpu_addr_r;
   assign bus.gpu_data_out = gpu_dout_r;
   assign bus.busy         = slot_vld;
   assign bus.overrun      = overrun_r;
endmodule

// File: tb/tb_gpu_ram_arbiter_n.sv
// tb_gpu_ram_arbiter_n: self-checking bench for gpu_ram_arbiter_n (PORTS=4,
// READ_CLOCK_CYCLES=2). The RAM is a ROM function behind a two-clock
// read pipe. A queue-based reference model predicts every output each clock.
// A stimulus table and hand-written sequences pin down specific corner cases.
module tb_gpu_ram_arbiter_n;
   localparam int P = 4;
   localparam int A = 20;
   localparam int D = 8;
   localparam int R = 2;
`ifdef GPU_RAM_ARB_RDLATCH_EN
   localparam int RL      = R + 1;
   localparam bit LATCHED = 1'b1;
`else
   localparam int RL      = R;
   localparam bit LATCHED = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   gpu_ram_arbiter_n_if #(.PORTS(P), .ADDR_W(A), .DATA_W(D)) bif ();

   gpu_ram_arbiter_n #(.PORTS(P), .ADDR_W(A), .DATA_W(D), .READ_CLOCK_CYCLES(R)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif.slave)
   );

   // RAM model: fixed contents, data valid two clocks after the address.
   function automatic logic [D-1:0] rom(input logic [A-1:0] a);
      return a[7:0] ^ a[15:8] ^ {a[19:16], 4'h5};
   endfunction

   logic [A-1:0] a1 = '0;
   logic [A-1:0] a2 = '0;
   always @(posedge clk) begin
      a1 <= bif.gpu_address;
      a2 <= a1;
   end
   assign bif.gpu_data_in = rom(a2);

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      int           due;
      int           port;
      logic [A-1:0] addr;
   } ret_t;

   bit           m_pend [P];
   bit           m_wr   [P];
   logic [A-1:0] m_addr [P];
   logic [D-1:0] m_data [P];
   int           m_ptr;
   int           edge_n;
   ret_t         rq [$];

   logic         e_we;
   logic [A-1:0] e_addr;
   logic [D-1:0] e_gd;
   logic [P-1:0] e_busy, e_ovr, e_rdy;
   logic [D-1:0] e_dout   [P];
   bit           e_dvalid [P];

   task automatic model_reset();
      for (int p = 0; p < P; p++) begin
         m_pend[p]   = 1'b0;
         e_dout[p]   = '0;
         e_dvalid[p] = LATCHED;
      end
      m_ptr  = 0;
      edge_n = 0;
      rq.delete();
      e_we   = 1'b0;
      e_addr = '0;
      e_gd   = '0;
      e_busy = '0;
      e_ovr  = '0;
      e_rdy  = '0;
   endtask

   // Predict outputs after the next rising edge from the request rules.
   task automatic model_edge(input logic [P-1:0] wr, input logic [P-1:0] rd,
                             input logic [P*A-1:0] ad, input logic [P*D-1:0] dt);
      int g;
      edge_n++;
      g = -1;
      for (int k = 0; k < P; k++) begin
         if (g < 0 && m_pend[(m_ptr + k) % P]) g = (m_ptr + k) % P;
      end
      e_we  = 1'b0;
      e_ovr = '0;
      e_rdy = '0;
      if (!LATCHED) for (int p = 0; p < P; p++) e_dvalid[p] = 1'b0;
      for (int i = rq.size() - 1; i >= 0; i--) begin
         if (rq[i].due == edge_n) begin
            e_rdy[rq[i].port]    = 1'b1;
            e_dout[rq[i].port]   = rom(rq[i].addr);
            e_dvalid[rq[i].port] = 1'b1;
            rq.delete(i);
         end
      end
      if (g >= 0) begin
         e_we   = m_wr[g];
         e_addr = m_addr[g];
         e_gd   = m_data[g];
         if (!m_wr[g]) rq.push_back('{edge_n + RL, g, m_addr[g]});
         m_pend[g] = 1'b0;
         m_ptr     = (g + 1) % P;
      end
      for (int p = 0; p < P; p++) begin
         if (wr[p] || rd[p]) begin
            if (m_pend[p]) begin
               e_ovr[p] = 1'b1;
            end else begin
               m_pend[p] = 1'b1;
               m_wr[p]   = wr[p];
               m_addr[p] = ad[p*A +: A];
               m_data[p] = dt[p*D +: D];
               if (wr[p] && rd[p]) e_ovr[p] = 1'b1;
            end
         end
      end
      for (int p = 0; p < P; p++) e_busy[p] = m_pend[p];
   endtask

   task automatic check_model();
      chk("busy", bif.busy, e_busy);
      chk("overrun", bif.overrun, e_ovr);
      chk("gpu_wr_ena", bif.gpu_wr_ena, e_we);
      chk("gpu_rd_rdy", bif.gpu_rd_rdy, e_rdy);
      chk("gpu_address", bif.gpu_address, e_addr);
      chk("gpu_data_out", bif.gpu_data_out, e_gd);
      for (int p = 0; p < P; p++) begin
         if (e_dvalid[p]) chk("data_out", bif.data_out[p*D +: D], e_dout[p]);
      end
   endtask

   task automatic check_reset_zero();
      chk("rst_gpu_wr_ena", bif.gpu_wr_ena, 0);
      chk("rst_gpu_address", bif.gpu_address, 0);
      chk("rst_gpu_data_out", bif.gpu_data_out, 0);
      chk("rst_gpu_rd_rdy", bif.gpu_rd_rdy, 0);
      chk("rst_data_out", bif.data_out, 0);
      chk("rst_busy", bif.busy, 0);
      chk("rst_overrun", bif.overrun, 0);
   endtask

   // Called at a falling edge: drive inputs, advance the model, check at the next falling edge.
   task automatic cycle(input logic [P-1:0] wr, input logic [P-1:0] rd,
                        input logic [P*A-1:0] ad, input logic [P*D-1:0] dt);
      bif.wr_ena  = wr;
      bif.rd_req  = rd;
      bif.address = ad;
      bif.data_in = dt;
      model_edge(wr, rd, ad, dt);
      @(negedge clk);
      check_model();
   endtask

   task automatic idle();
      cycle('0, '0, '0, '0);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic [P-1:0]   wr;
      logic [P-1:0]   rd;
      logic [P*A-1:0] ad;
      logic [P*D-1:0] dt;
      logic [P-1:0]   busy;
      logic [P-1:0]   ovr;
      logic           we;
      logic [A-1:0]   addr;
      logic [D-1:0]   gd;
   } vec_t;

   function automatic vec_t mk(input logic [P-1:0] wr, input logic [P-1:0] rd,
                               input logic [P*A-1:0] ad, input logic [P*D-1:0] dt,
                               input logic [P-1:0] busy, input logic [P-1:0] ovr,
                               input logic we, input logic [A-1:0] addr, input logic [D-1:0] gd);
      vec_t v;
      v.wr = wr; v.rd = rd; v.ad = ad; v.dt = dt;
      v.busy = busy; v.ovr = ovr; v.we = we; v.addr = addr; v.gd = gd;
      return v;
   endfunction

   localparam int NV = 12;
   vec_t vec [NV];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, actual time %0t, required under 200000", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int t_addr, t_rdy, t1, t2, found, rdy_cnt;
      logic [D-1:0] got, d1, d2, d1_hold;
      logic [P-1:0] wr, rd;
      logic [P*A-1:0] ad;
      logic [P*D-1:0] dt;

      vec[0]  = mk(4'hF, 4'h0, {20'h00103, 20'h00102, 20'h00101, 20'h00100}, {8'hA3, 8'hA2, 8'hA1, 8'hA0},
                   4'hF, 4'h0, 1'b0, 20'h00000, 8'h00);
      vec[1]  = mk(4'h0, 4'h0, '0, '0, 4'hE, 4'h0, 1'b1, 20'h00100, 8'hA0);
      vec[2]  = mk(4'h0, 4'h0, '0, '0, 4'hC, 4'h0, 1'b1, 20'h00101, 8'hA1);
      vec[3]  = mk(4'h0, 4'h0, '0, '0, 4'h8, 4'h0, 1'b1, 20'h00102, 8'hA2);
      vec[4]  = mk(4'h0, 4'h0, '0, '0, 4'h0, 4'h0, 1'b1, 20'h00103, 8'hA3);
      vec[5]  = mk(4'h3, 4'h2, {20'h0, 20'h0, 20'h00200, 20'h00050}, {8'h0, 8'h0, 8'h55, 8'h11},
                   4'h3, 4'h2, 1'b0, 20'h00103, 8'hA3);
      vec[6]  = mk(4'h0, 4'h2, {20'h0, 20'h0, 20'h00300, 20'h0}, '0, 4'h2, 4'h2, 1'b1, 20'h00050, 8'h11);
      vec[7]  = mk(4'h0, 4'h0, '0, '0, 4'h0, 4'h0, 1'b1, 20'h00200, 8'h55);
      vec[8]  = mk(4'h0, 4'h1, {60'h0, 20'h0ABCD}, '0, 4'h1, 4'h0, 1'b0, 20'h00200, 8'h55);
      vec[9]  = mk(4'h0, 4'h0, '0, '0, 4'h0, 4'h0, 1'b0, 20'h0ABCD, 8'h00);
      vec[10] = mk(4'h0, 4'h0, '0, '0, 4'h0, 4'h0, 1'b0, 20'h0ABCD, 8'h00);
      vec[11] = mk(4'h0, 4'h0, '0, '0, 4'h0, 4'h0, 1'b0, 20'h0ABCD, 8'h00);

      bif.wr_ena  = '0;
      bif.rd_req  = '0;
      bif.address = '0;
      bif.data_in = '0;
      reset       = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_zero();
      reset = 1'b0;

      // simultaneous writes, overrun cases, a read
      for (int i = 0; i < NV; i++) begin
         cycle(vec[i].wr, vec[i].rd, vec[i].ad, vec[i].dt);
         chk($sformatf("tbl%0d_busy", i), bif.busy, vec[i].busy);
         chk($sformatf("tbl%0d_overrun", i), bif.overrun, vec[i].ovr);
         chk($sformatf("tbl%0d_gpu_wr_ena", i), bif.gpu_wr_ena, vec[i].we);
         chk($sformatf("tbl%0d_gpu_address", i), bif.gpu_address, vec[i].addr);
         chk($sformatf("tbl%0d_gpu_data_out", i), bif.gpu_data_out, vec[i].gd);
      end
      repeat (3) idle();

      // single read latency from port 0
      cycle('0, 4'b0001, {60'h0, 20'h12345}, '0);
      t_addr = -1;
      t_rdy  = -1;
      got    = '0;
      for (int j = 1; j <= 8; j++) begin
         idle();
         if (t_addr < 0 && bif.gpu_address == 20'h12345) t_addr = j;
         if (t_rdy < 0 && bif.gpu_rd_rdy[0]) begin
            t_rdy = j;
            got   = bif.data_out[D-1:0];
         end
      end
      chk("single_read_addr_latency", t_addr, 1);
      chk("single_read_rdy_latency", t_rdy, 1 + RL);
      chk("single_read_data", got, rom(20'h12345));

      // fairness: port 0 hammers, port 2 must still get through
      cycle('0, 4'b0101, {20'h0, 20'h22222, 20'h0, 20'h00010}, '0);
      found = -1;
      for (int j = 1; j <= 6; j++) begin
         cycle('0, 4'b0001, {60'h0, 20'h00010}, '0);
         if (found < 0 && bif.gpu_address == 20'h22222 && !bif.gpu_wr_ena) found = j;
      end
      chk("fair_port2_grant_by_e4", (found >= 1 && found <= 4) ? 1 : 0, 1);
      repeat (RL + 3) idle();

      // back-to-back reads from ports 1 and 2
      cycle('0, 4'b0110, {20'h0, 20'h22220, 20'h11111, 20'h0}, '0);
      t1 = -1;
      t2 = -1;
      d1 = '0;
      d2 = '0;
      d1_hold = '0;
      for (int j = 1; j <= 8; j++) begin
         idle();
         if (t1 < 0 && bif.gpu_rd_rdy[1]) begin
            t1 = j;
            d1 = bif.data_out[D +: D];
         end
         if (t2 < 0 && bif.gpu_rd_rdy[2]) begin
            t2      = j;
            d2      = bif.data_out[2*D +: D];
            d1_hold = bif.data_out[D +: D];
         end
      end
      chk("b2b_rdy1_latency", t1, 1 + RL);
      chk("b2b_rdy2_consecutive", t2, t1 + 1);
      chk("b2b_data1", d1, rom(20'h11111));
      chk("b2b_data2", d2, rom(20'h22220));
`ifdef GPU_RAM_ARB_RDLATCH_EN
      chk("latch_hold_port1", d1_hold, rom(20'h11111));
`endif

      // reset one clock after a read grant
      cycle('0, 4'b1000, {20'h33333, 60'h0}, '0);
      idle();
      idle();
      bif.rd_req = '0;
      reset      = 1'b1;
      model_reset();
      #1;
      check_reset_zero();
      @(negedge clk);
      check_reset_zero();
      @(negedge clk);
      check_reset_zero();
      reset   = 1'b0;
      rdy_cnt = 0;
      for (int j = 1; j <= 6; j++) begin
         idle();
         if (bif.gpu_rd_rdy != '0) rdy_cnt++;
      end
      chk("no_rdy_after_reset", rdy_cnt, 0);

      // randomized traffic against the model
      for (int k = 0; k < 400; k++) begin
         for (int p = 0; p < P; p++) begin
            wr[p] = ($urandom_range(0, 3) == 0);
            rd[p] = ($urandom_range(0, 2) == 0);
            ad[p*A +: A] = 20'($urandom);
            dt[p*D +: D] = 8'($urandom);
         end
         cycle(wr, rd, ad, dt);
      end
      repeat (RL + 4) idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
